// File: rtl/weight_fifo_bank_if.sv
// Bus bundle for the per-lane weight FIFO bank.
//
// Transfer semantics (there is no back-pressure, so nothing here is a ready):
//   - push side: on a rising clk edge, every lane i with fifo_en[i]=1 offers
//     w_mem_rd_data lane i. It is stored if the lane has room or pops on that
//     same edge. Otherwise it is dropped and ovf_err latches.
//   - output side: w_out lane i is meaningful only while w_out_valid[i]=1.
//     It reads as 0 whenever w_out_valid[i]=0.
interface weight_fifo_bank_if #(
  parameter int FIFO_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic [FIFO_WIDTH-1:0]            fifo_en;
  logic [FIFO_WIDTH*DATA_WIDTH-1:0] w_mem_rd_data;
  logic                             drain;
  logic [FIFO_WIDTH*DATA_WIDTH-1:0] w_out;
  logic [FIFO_WIDTH-1:0]            w_out_valid;
  logic [FIFO_WIDTH-1:0]            full;
  logic [FIFO_WIDTH-1:0]            empty;
  logic                             busy;
  logic                             ovf_err;
  logic                             udf_err;
  logic                             dbg_state;  // drain FSM state, 1 = DRAIN

  modport master (
    output fifo_en, w_mem_rd_data, drain,
    input  w_out, w_out_valid, full, empty, busy, ovf_err, udf_err, dbg_state
  );

  modport slave (
    input  fifo_en, w_mem_rd_data, drain,
    output w_out, w_out_valid, full, empty, busy, ovf_err, udf_err, dbg_state
  );
endinterface

// File: rtl/weight_fifo_bank.sv
// Per-lane weight FIFO bank. Each lane captures one weight per fifo_en strobe.
// A drain command replays every lane into the systolic array with a diagonal
// skew: lane i starts i cycles after lane 0 and pops n times, where n is
// lane 0's occupancy when the drain was accepted.
module weight_fifo_bank #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic clk,
  input  logic rstn,
  weight_fifo_bank_if.slave bus
);

  localparam int PTR_WIDTH   = $clog2(FIFO_DEPTH);
  localparam int COUNT_WIDTH = PTR_WIDTH + 1;
  localparam int K_WIDTH     = $clog2(FIFO_DEPTH + FIFO_WIDTH) + 1;
  // One extra bit so that lane + n and n + FIFO_WIDTH - 2 never wrap.
  localparam int CMP_WIDTH   = K_WIDTH + 1;
  localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(FIFO_DEPTH);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t                   state, state_nxt;
  logic [K_WIDTH-1:0]       k, k_nxt;
  logic [COUNT_WIDTH-1:0]   n, n_nxt;
  logic [COUNT_WIDTH-1:0]   count0;
  logic [CMP_WIDTH-1:0]     k_ext, n_ext, k_last;

  logic [FIFO_WIDTH-1:0]    pop, push, pop_ok, drop, pop_empty;
  logic [FIFO_WIDTH-1:0]    full_v, empty_v, valid_v;
  logic [FIFO_WIDTH*DATA_WIDTH-1:0] w_out_v;
  logic                     ovf_q, udf_q;

  assign k_ext  = CMP_WIDTH'(k);
  assign n_ext  = CMP_WIDTH'(n);
  assign k_last = n_ext + CMP_WIDTH'(FIFO_WIDTH) - CMP_WIDTH'(2);

  // Drain FSM registers: state, skew counter and the lane-0 depth snapshot.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      k     <= '0;
      n     <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      n     <= n_nxt;
    end
  end

  // Next-state logic; drains are only accepted from IDLE with lane 0 non-empty.
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    n_nxt     = n;
    case (state)
      IDLE: begin
        if (bus.drain && (count0 != '0)) begin
          state_nxt = DRAIN;
          k_nxt     = '0;
          n_nxt     = count0;
        end
      end
      DRAIN: begin
        k_nxt = k + K_WIDTH'(1);
        if (k_ext == k_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar i = 0; i < FIFO_WIDTH; i++) begin : g_lane
    localparam logic [CMP_WIDTH-1:0] LANE = CMP_WIDTH'(i);

    logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]   wr_ptr, rd_ptr;
    logic [COUNT_WIDTH-1:0] count;
    logic [DATA_WIDTH-1:0]  out_q;
    logic                   valid_q;

    // A full lane may still accept a push when it pops on the same edge.
    assign pop[i]       = (state == DRAIN) && (k_ext >= LANE) && (k_ext < LANE + n_ext);
    assign full_v[i]    = (count == FULL_COUNT);
    assign empty_v[i]   = (count == '0);
    assign push[i]      = bus.fifo_en[i] && (!full_v[i] || pop[i]);
    assign drop[i]      = bus.fifo_en[i] && full_v[i] && !pop[i];
    assign pop_ok[i]    = pop[i] && !empty_v[i];
    assign pop_empty[i] = pop[i] && empty_v[i];
    assign valid_v[i]   = valid_q;
    assign w_out_v[i*DATA_WIDTH +: DATA_WIDTH] = out_q;

    // Storage write port; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
      if (push[i]) mem[wr_ptr] <= bus.w_mem_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Pointers, occupancy and the registered output slot for this lane.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count   <= '0;
        out_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        if (push[i])   wr_ptr <= wr_ptr + PTR_WIDTH'(1);
        if (pop_ok[i]) rd_ptr <= rd_ptr + PTR_WIDTH'(1);
        case ({push[i], pop_ok[i]})
          2'b10:   count <= count + COUNT_WIDTH'(1);
          2'b01:   count <= count - COUNT_WIDTH'(1);
          default: count <= count;
        endcase
        out_q   <= pop_ok[i] ? mem[rd_ptr] : '0;
        valid_q <= pop_ok[i];
      end
    end

    if (i == 0) begin : g_count0
      assign count0 = count;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (|drop)      ovf_q <= 1'b1;
      if (|pop_empty) udf_q <= 1'b1;
    end
  end

  assign bus.w_out       = w_out_v;
  assign bus.w_out_valid = valid_v;
  assign bus.full        = full_v;
  assign bus.empty       = empty_v;
  assign bus.busy        = (state == DRAIN);
  assign bus.dbg_state   = state;
  assign bus.ovf_err     = ovf_q;
  assign bus.udf_err     = udf_q;

endmodule

// File: tb/tb_weight_fifo_bank.sv
// Bench for weight_fifo_bank: queue-based reference model plus directed and
// random scenarios, each task checking its own observations.
module tb_weight_fifo_bank;

  localparam int FW = 16;
  localparam int FD = 16;
  localparam int DW = 8;
  localparam int VW = FW*DW + 3*FW + 4;

  logic clk;
  logic rstn;
  int   total;
  int   bad;

  weight_fifo_bank_if #(.FIFO_WIDTH(FW), .DATA_WIDTH(DW)) wif ();

  weight_fifo_bank #(.FIFO_WIDTH(FW), .FIFO_DEPTH(FD), .DATA_WIDTH(DW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (wif.slave)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  logic [DW-1:0]    mq [FW][$];
  logic [FW*DW-1:0] m_out;
  logic [FW-1:0]    m_valid;
  logic             m_ovf, m_udf;
  int               m_left;   // drain cycles still to run, 0 = idle
  int               m_n;

  function automatic void model_reset();
    for (int i = 0; i < FW; i++) mq[i].delete();
    m_out = '0; m_valid = '0; m_ovf = 1'b0; m_udf = 1'b0; m_left = 0; m_n = 0;
  endfunction

  function automatic void model_edge(logic [FW-1:0] en, logic [FW*DW-1:0] data, logic drn);
    logic [FW*DW-1:0] nout;
    logic [FW-1:0]    nval;
    bit               draining;
    int               t, sz, sz0;
    bit               p;
    nout = '0;
    nval = '0;
    draining = (m_left > 0);
    t   = m_n + FW - 1 - m_left;   // cycles already spent draining
    sz0 = mq[0].size();
    for (int i = 0; i < FW; i++) begin
      // lane i pops m_n times, starting i cycles after lane 0
      p  = draining && (t >= i) && (t < i + m_n);
      sz = mq[i].size();
      if (p) begin
        if (sz > 0) begin
          nout[i*DW +: DW] = mq[i].pop_front();
          nval[i] = 1'b1;
        end else begin
          m_udf = 1'b1;
        end
      end
      if (en[i]) begin
        if (sz < FD || p) mq[i].push_back(data[i*DW +: DW]);
        else m_ovf = 1'b1;
      end
    end
    m_out = nout;
    m_valid = nval;
    if (draining) m_left--;
    else if (drn && sz0 > 0) begin
      m_n = sz0;
      m_left = sz0 + FW - 1;
    end
  endfunction

  function automatic logic [VW-1:0] model_vec();
    logic [FW-1:0] f, e;
    for (int i = 0; i < FW; i++) begin
      f[i] = (mq[i].size() == FD);
      e[i] = (mq[i].size() == 0);
    end
    return {m_out, m_valid, f, e, (m_left > 0), (m_left > 0), m_ovf, m_udf};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {wif.w_out, wif.w_out_valid, wif.full, wif.empty, wif.busy, wif.dbg_state,
            wif.ovf_err, wif.udf_err};
  endfunction

  // ---------------- drivers ----------------
  task automatic cycle(input logic [FW-1:0] en, input logic [FW*DW-1:0] data, input logic drn);
    wif.fifo_en = en;
    wif.w_mem_rd_data = data;
    wif.drain = drn;
    @(posedge clk);
    model_edge(en, data, drn);
    #1;
  endtask

  task automatic apply_reset();
    wif.fifo_en = '0;
    wif.w_mem_rd_data = '0;
    wif.drain = 1'b0;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  function automatic logic [FW*DW-1:0] rand_data();
    logic [FW*DW-1:0] d;
    for (int i = 0; i < FW; i++) d[i*DW +: DW] = DW'($urandom_range(0, 255));
    return d;
  endfunction

  function automatic logic [FW*DW-1:0] fill_data(int j);
    logic [FW*DW-1:0] d;
    for (int i = 0; i < FW; i++) d[i*DW +: DW] = {4'(i), 4'(j)};
    return d;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rstn = 1'b0;
    for (int c = 0; c < 4; c++) begin
      wif.fifo_en = FW'($urandom);
      wif.w_mem_rd_data = rand_data();
      wif.drain = 1'($urandom);
      @(posedge clk);
      #1;
    end
    total++; if (wif.empty !== 16'hFFFF) begin bad++; $display("FAIL reset_empty got=%h want=ffff", wif.empty); end
    total++; if (wif.full !== 16'h0000) begin bad++; $display("FAIL reset_full got=%h want=0000", wif.full); end
    total++; if (wif.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", wif.busy); end
    total++; if (wif.w_out_valid !== 16'h0000 || wif.w_out !== '0) begin
      bad++; $display("FAIL reset_out got_valid=%h got_out=%h want=0", wif.w_out_valid, wif.w_out);
    end
    total++; if ({wif.ovf_err, wif.udf_err} !== 2'b00) begin
      bad++; $display("FAIL reset_err got=%b%b want=00", wif.ovf_err, wif.udf_err);
    end
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      cycle('0, '0, 1'b0);
      total++; if (dut_vec() !== model_vec()) begin bad++; $display("FAIL reset_idle cyc=%0d got=%h want=%h", c, dut_vec(), model_vec()); end
    end
    total++; if (wif.empty !== 16'hFFFF) begin bad++; $display("FAIL reset_release_empty got=%h want=ffff", wif.empty); end
  endtask

  task automatic test_fill_drain();
    int busy_cnt;
    logic [FW*DW-1:0] ed;
    logic [FW-1:0] ev;
    apply_reset();
    for (int j = 0; j < FD; j++) begin
      cycle('1, fill_data(j), 1'b0);
      total++; if (dut_vec() !== model_vec()) begin bad++; $display("FAIL fill cyc=%0d got=%h want=%h", j, dut_vec(), model_vec()); end
    end
    total++; if (wif.full !== 16'hFFFF) begin bad++; $display("FAIL fill_full got=%h want=ffff", wif.full); end
    cycle('0, '0, 1'b1);
    total++; if (wif.busy !== 1'b1) begin bad++; $display("FAIL drain_start_busy got=%b want=1", wif.busy); end
    busy_cnt = 1;
    for (int c = 1; c <= 33; c++) begin
      cycle('0, '0, 1'b0);
      if (wif.busy === 1'b1) busy_cnt++;
      ed = '0;
      ev = '0;
      for (int i = 0; i < FW; i++) begin
        if (c >= i + 1 && c <= i + 16) begin
          ev[i] = 1'b1;
          ed[i*DW +: DW] = {4'(i), 4'(c - i - 1)};
        end
      end
      total++; if ({wif.w_out_valid, wif.w_out} !== {ev, ed}) begin
        bad++; $display("FAIL drain_stream cyc=%0d got=%h/%h want=%h/%h", c, wif.w_out_valid, wif.w_out, ev, ed);
      end
      total++; if (dut_vec() !== model_vec()) begin bad++; $display("FAIL drain_model cyc=%0d got=%h want=%h", c, dut_vec(), model_vec()); end
    end
    total++; if (busy_cnt != 31) begin bad++; $display("FAIL drain_busy_len got=%0d want=31", busy_cnt); end
  endtask

  task automatic test_overflow();
    logic [FW*DW-1:0] d;
    int aa_seen;
    apply_reset();
    for (int j = 0; j < FD; j++) begin
      for (int i = 0; i < FW; i++) d[i*DW +: DW] = DW'($urandom_range(0, 169));
      cycle('1, d, 1'b0);
    end
    cycle('1, {FW{8'hAA}}, 1'b0);
    total++; if (wif.ovf_err !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", wif.ovf_err); end
    total++; if (wif.full !== 16'hFFFF) begin bad++; $display("FAIL ovf_full got=%h want=ffff", wif.full); end
    cycle('0, '0, 1'b1);
    aa_seen = 0;
    for (int c = 1; c <= 33; c++) begin
      cycle('0, '0, 1'b0);
      for (int i = 0; i < FW; i++)
        if (wif.w_out_valid[i] === 1'b1 && wif.w_out[i*DW +: DW] === 8'hAA) aa_seen++;
      total++; if (dut_vec() !== model_vec()) begin bad++; $display("FAIL ovf_drain cyc=%0d got=%h want=%h", c, dut_vec(), model_vec()); end
    end
    total++; if (aa_seen != 0) begin bad++; $display("FAIL ovf_dropped_data got=%0d want=0", aa_seen); end
  endtask

  task automatic test_push_during_drain();
    int pushed [FW];
    int seen [FW];
    logic [FW-1:0] mask;
    logic [FW-1:0] exp_empty;
    apply_reset();
    for (int i = 0; i < FW; i++) begin pushed[i] = 0; seen[i] = 0; end
    for (int j = 0; j < FD; j++) cycle('1, rand_data(), 1'b0);
    cycle('0, '0, 1'b1);
    for (int k = 0; k < 16; k++) begin
      mask = FW'($urandom);
      for (int i = 0; i < FW; i++) if (i > k) mask[i] = 1'b0;
      mask[0] = 1'b1;
      for (int i = 0; i < FW; i++) if (mask[i]) pushed[i]++;
      cycle(mask, rand_data(), 1'b0);
      total++; if (dut_vec() !== model_vec()) begin bad++; $display("FAIL pdd_push k=%0d got=%h want=%h", k, dut_vec(), model_vec()); end
    end
    for (int c = 0; c < 16; c++) begin
      cycle('0, '0, 1'b0);
      total++; if (dut_vec() !== model_vec()) begin bad++; $display("FAIL pdd_tail cyc=%0d got=%h want=%h", c, dut_vec(), model_vec()); end
    end
    total++; if (wif.ovf_err !== 1'b0 || wif.busy !== 1'b0) begin
      bad++; $display("FAIL pdd_end got_ovf=%b got_busy=%b want=0/0", wif.ovf_err, wif.busy);
    end
    for (int i = 0; i < FW; i++) exp_empty[i] = (pushed[i] == 0);
    total++; if (wif.empty !== exp_empty || wif.full[0] !== 1'b1) begin
      bad++; $display("FAIL pdd_occupancy got_empty=%h got_full0=%b want=%h/1", wif.empty, wif.full[0], exp_empty);
    end
    cycle('0, '0, 1'b1);
    for (int c = 0; c < 32; c++) begin
      cycle('0, '0, 1'b0);
      for (int i = 0; i < FW; i++) if (wif.w_out_valid[i] === 1'b1) seen[i]++;
      total++; if (dut_vec() !== model_vec()) begin bad++; $display("FAIL pdd_redrain cyc=%0d got=%h want=%h", c, dut_vec(), model_vec()); end
    end
    for (int i = 0; i < FW; i++) begin
      total++; if (seen[i] != pushed[i]) begin bad++; $display("FAIL pdd_count lane=%0d got=%0d want=%0d", i, seen[i], pushed[i]); end
    end
  endtask

  task automatic test_edge_drains();
    logic [3:0] l3;
    int l3_cnt;
    apply_reset();
    cycle('0, '0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      total++; if (wif.busy !== 1'b0) begin bad++; $display("FAIL empty_drain_busy cyc=%0d got=%b want=0", c, wif.busy); end
      cycle('0, '0, 1'b0);
    end
    cycle(16'h0009, rand_data(), 1'b0);
    cycle(16'h0009, rand_data(), 1'b0);
    cycle(16'h0001, rand_data(), 1'b0);
    cycle(16'h0001, rand_data(), 1'b0);
    cycle('0, '0, 1'b1);
    l3 = '0;
    l3_cnt = 0;
    for (int c = 1; c <= 24; c++) begin
      cycle('0, '0, 1'b0);
      if (wif.w_out_valid[3] === 1'b1) l3_cnt++;
      if (c >= 4 && c <= 7) l3[c-4] = wif.w_out_valid[3];
      total++; if (dut_vec() !== model_vec()) begin bad++; $display("FAIL edge_drain cyc=%0d got=%h want=%h", c, dut_vec(), model_vec()); end
    end
    total++; if (l3 !== 4'b0011 || l3_cnt != 2) begin
      bad++; $display("FAIL lane3_slots got=%b cnt=%0d want=0011 cnt=2", l3, l3_cnt);
    end
    total++; if (wif.udf_err !== 1'b1) begin bad++; $display("FAIL udf_flag got=%b want=1", wif.udf_err); end
  endtask

  task automatic test_reset_mid_drain();
    apply_reset();
    for (int j = 0; j < FD; j++) cycle('1, rand_data(), 1'b0);
    cycle('0, '0, 1'b1);
    repeat (5) cycle('0, '0, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    total++; if ({wif.w_out_valid, wif.w_out} !== '0) begin
      bad++; $display("FAIL async_rst_out got=%h/%h want=0", wif.w_out_valid, wif.w_out);
    end
    total++; if ({wif.full, wif.empty, wif.busy, wif.ovf_err, wif.udf_err} !== {16'h0000, 16'hFFFF, 3'b000}) begin
      bad++; $display("FAIL async_rst_flags got=%h/%h/%b%b%b want=0000/ffff/000",
                      wif.full, wif.empty, wif.busy, wif.ovf_err, wif.udf_err);
    end
    model_reset();
    #2;
    rstn = 1'b1;
    for (int j = 0; j < 5; j++) cycle(FW'($urandom) | FW'(1), rand_data(), 1'b0);
    cycle('0, '0, 1'b1);
    for (int c = 0; c < 24; c++) begin
      cycle('0, '0, 1'b0);
      total++; if (dut_vec() !== model_vec()) begin bad++; $display("FAIL post_rst_drain cyc=%0d got=%h want=%h", c, dut_vec(), model_vec()); end
    end
  endtask

  task automatic test_random();
    logic [FW-1:0] en;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      en = ($urandom_range(0, 3) == 0) ? '0 : FW'($urandom);
      cycle(en, rand_data(), ($urandom_range(0, 15) == 0));
      total++; if (dut_vec() !== model_vec()) begin bad++; $display("FAIL random cyc=%0d got=%h want=%h", c, dut_vec(), model_vec()); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    total = 0;
    bad = 0;
    rstn = 1'b0;
    wif.fifo_en = '0;
    wif.w_mem_rd_data = '0;
    wif.drain = 1'b0;
    model_reset();
    test_reset();
    test_fill_drain();
    test_overflow();
    test_push_during_drain();
    test_edge_drains();
    test_reset_mid_drain();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
